alu_seq: RTL

- Parametrised, registered successor to the team's 8-bit combinational ALU; same 16-opcode map, width generalised to WIDTH.
- Adds iterative multi-cycle multiply/divide, valid/ready handshakes on both sides, registered flags (C, Z, V, DZ).
- Sits between the operand register file and the writeback stage.
- Accepts one operation at a time. The result is held until the consumer takes it.

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with the 16-opcode map, generalised to WIDTH bits.
// Multiply and divide run iteratively, one bit per cycle; results are held until consumed.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [WIDTH-1:0]     Operand1,
  input  logic [WIDTH-1:0]     Operand2,
  input  logic [3:0]           Opcode,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [2*WIDTH-1:0]   Result,
  output logic                 flagC,
  output logic                 flagZ,
  output logic                 flagV,
  output logic                 flagDZ
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_result, r_prod, r_mcand;
  logic [WIDTH-1:0]     r_mplier, r_rem, r_quo, r_div;
  logic                 r_c, r_z, r_v, r_dz;

  logic                 w_accept, w_iterative, w_lastStep;
  logic [WIDTH:0]       w_sum, w_diff, w_divShift, w_divTrial;
  logic [2*WIDTH-1:0]   w_single, w_prodNext;
  logic [WIDTH-1:0]     w_remNext, w_quoNext;
  logic                 w_sC, w_sV, w_sDZ;

  assign w_accept    = InValid && (r_state == IDLE);
  assign w_iterative = (Opcode == OP_MUL) || ((Opcode == OP_DIV) && (Operand2 != '0));
  assign w_lastStep  = (r_cnt == LAST);

  assign w_sum  = {1'b0, Operand1} + {1'b0, Operand2};
  assign w_diff = {1'b0, Operand1} - {1'b0, Operand2};

  assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);

  // Restoring step: the top bit of the trial difference is the borrow, so a clear bit means subtract.
  assign w_divShift = {r_rem, r_quo[WIDTH-1]};
  assign w_divTrial = w_divShift - {1'b0, r_div};
  assign w_remNext  = w_divTrial[WIDTH] ? w_divShift[WIDTH-1:0] : w_divTrial[WIDTH-1:0];
  assign w_quoNext  = {r_quo[WIDTH-2:0], ~w_divTrial[WIDTH]};

  always_comb begin
    w_single = '0;
    w_sC     = 1'b0;
    w_sV     = 1'b0;
    w_sDZ    = 1'b0;
    case (Opcode)
      4'b0000: begin
        w_single = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_sC     = w_sum[WIDTH];
        w_sV     = (Operand1[WIDTH-1] == Operand2[WIDTH-1]) && (w_sum[WIDTH-1] != Operand1[WIDTH-1]);
      end
      4'b0001: begin
        w_single = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_sC     = w_diff[WIDTH];
        w_sV     = (Operand1[WIDTH-1] != Operand2[WIDTH-1]) && (w_diff[WIDTH-1] != Operand1[WIDTH-1]);
      end
      4'b0011: begin
        w_single = {Operand1, {WIDTH{1'b1}}};
        w_sDZ    = 1'b1;
      end
      4'b0100: w_single = {{(WIDTH-1){1'b0}}, Operand1, 1'b0};
      4'b0101: w_single = {{(WIDTH+1){1'b0}}, Operand1[WIDTH-1:1]};
      4'b0110: w_single = {{WIDTH{1'b0}}, Operand1[WIDTH-2:0], Operand1[WIDTH-1]};
      4'b0111: w_single = {{WIDTH{1'b0}}, Operand1[0], Operand1[WIDTH-1:1]};
      4'b1000: w_single = {{WIDTH{1'b0}}, Operand1 & Operand2};
      4'b1001: w_single = {{WIDTH{1'b0}}, Operand1 | Operand2};
      4'b1010: w_single = {{WIDTH{1'b0}}, Operand1 ^ Operand2};
      4'b1011: w_single = {{WIDTH{1'b0}}, ~(Operand1 | Operand2)};
      4'b1100: w_single = {{WIDTH{1'b0}}, ~(Operand1 & Operand2)};
      4'b1101: w_single = {{WIDTH{1'b0}}, ~(Operand1 ^ Operand2)};
      4'b1110: w_single = {{(2*WIDTH-1){1'b0}}, Operand1 > Operand2};
      4'b1111: w_single = {{(2*WIDTH-1){1'b0}}, Operand1 == Operand2};
      default: w_single = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (Opcode == OP_MUL)      w_next = MUL;
        else if (w_iterative)      w_next = DIV;
        else                       w_next = DONE;
      end
      MUL, DIV: if (w_lastStep) w_next = DONE;
      DONE: if (OutReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    InReady  = (r_state == IDLE);
    OutValid = (r_state == DONE);
    Result   = r_result;
    flagC    = r_c;
    flagZ    = r_z;
    flagV    = r_v;
    flagDZ   = r_dz;
  end

  // Datapath: operand capture on accept, one iteration per MUL/DIV cycle, result/flags on completion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_cnt    <= '0;
          r_prod   <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, Operand1};
          r_mplier <= Operand2;
          r_rem    <= '0;
          r_quo    <= Operand1;
          r_div    <= Operand2;
          if (!w_iterative) begin
            r_result <= w_single;
            r_c      <= w_sC;
            r_z      <= (w_single == '0);
            r_v      <= w_sV;
            r_dz     <= w_sDZ;
          end
        end
        MUL: begin
          r_prod   <= w_prodNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_lastStep) begin
            r_result <= w_prodNext;
            r_c      <= 1'b0;
            r_z      <= (w_prodNext == '0);
            r_v      <= 1'b0;
            r_dz     <= 1'b0;
          end
        end
        DIV: begin
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          r_cnt <= r_cnt + 1'b1;
          if (w_lastStep) begin
            r_result <= {w_remNext, w_quoNext};
            r_c      <= 1'b0;
            r_z      <= ({w_remNext, w_quoNext} == '0);
            r_v      <= 1'b0;
            r_dz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
